// File: rtl/fsm_k_responder.sv
// Target-side responder for the FSM k read handshake: answers rd/ds with ws and
// burst read data from a host-loadable register-file memory, and flags sequencing errors.
module fsm_k_responder #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd,
  input  logic          ds,
  input  logic [AW-1:0] start_addr,
  input  logic [LW-1:0] burst_len,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic          ws,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] beat_cnt
);

  // state  | meaning
  // R_IDLE | no burst in progress, waiting for the first READ
  // R_PH2  | initiator DLY cycle: rdata valid, ws presented
  // R_PH1  | initiator READ of a later beat
  // R_WDS  | last beat delivered, expecting ds
  // R_ERR  | protocol violation, held until rd=ds=0
  typedef enum logic [2:0] {R_IDLE, R_PH2, R_PH1, R_WDS, R_ERR} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] addr;
  logic [LW-1:0] rem;
  logic          ld_first, ld_next, step, count, done_nxt, more;

  assign more = (rem > LW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= R_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_first  = 1'b0;
    ld_next   = 1'b0;
    step      = 1'b0;
    count     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      R_IDLE: begin
        if (rd) begin
          ld_first  = 1'b1;
          state_nxt = R_PH2;
        end else if (ds) begin
          state_nxt = R_ERR;
        end
      end
      R_PH2: begin
        if (!rd) begin
          state_nxt = R_ERR;
        end else begin
          count = 1'b1;
          if (more) begin
            step      = 1'b1;
            state_nxt = R_PH1;
          end else begin
            state_nxt = R_WDS;
          end
        end
      end
      R_PH1: begin
        if (rd) begin
          ld_next   = 1'b1;
          state_nxt = R_PH2;
        end else begin
          state_nxt = R_ERR;
        end
      end
      R_WDS: begin
        if (ds && !rd) begin
          done_nxt  = 1'b1;
          state_nxt = R_IDLE;
        end else begin
          state_nxt = R_ERR;
        end
      end
      R_ERR: begin
        if (!rd && !ds) state_nxt = R_IDLE;
      end
      default: state_nxt = R_IDLE;
    endcase
  end

  // ws/rvalid/err come from registered state only, never from same-cycle inputs
  assign rvalid = (state == R_PH2);
  assign ws     = (state == R_PH2) && more;
  assign err    = (state == R_ERR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr     <= '0;
      rem      <= '0;
      rdata    <= '0;
      beat_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= done_nxt;
      if (ld_first) begin
        addr     <= start_addr;
        rem      <= (burst_len == '0) ? LW'(1) : burst_len;
        rdata    <= mem[start_addr];
        beat_cnt <= '0;
      end
      if (ld_next) rdata <= mem[addr];
      if (step) begin
        addr <= addr + AW'(1);
        rem  <= rem - LW'(1);
      end
      if (count) beat_cnt <= beat_cnt + LW'(1);
    end
  end

  // Unreset memory; a same-edge read of the written address returns the old word
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: doc/fsm_k_responder.md
Name: fsm_k_responder

Overview:
- Target-side responder for the FSM k read handshake. The initiator drives rd and ds; this block answers with ws and read data.
- Serves a burst of sequential words from an internal register-file memory. ws=1 requests another beat; ws=0 ends the burst.
- Checks the initiator's rd/ds sequencing and flags protocol errors.
- A host port preloads the memory.

Parameters:
- DW, 8, data word width.
- AW, 4, address width; memory depth is 2**AW words.
- LW, 4, burst-length field width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- rd  input  1  initiator read strobe. High for two consecutive cycles per beat: READ, then DLY.
- ds  input  1  initiator done strobe. One cycle after the last DLY.
- start_addr  input  AW  burst base address, sampled at burst start.
- burst_len  input  LW  beats per burst, sampled at burst start; 0 is treated as 1.
- we  input  1  host memory write enable.
- waddr  input  AW  host write address.
- wdata  input  DW  host write data.
- ws  output  1  wait/continue; valid in the initiator's DLY cycle.
- rvalid  output  1  rdata valid (DLY cycle of each beat).
- rdata  output  DW  read data, registered.
- done  output  1  one-cycle pulse on clean burst completion.
- err  output  1  protocol error indication.
- beat_cnt  output  LW  beats delivered in the current or last burst.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=R_IDLE; ws=0, rvalid=0, rdata=0, done=0, err=0, beat_cnt=0.
  - Memory contents are not reset.
  - A reset mid-burst aborts the burst with no done pulse.
- States: R_IDLE, R_PH2 (initiator DLY), R_PH1 (initiator READ of a later beat), R_WDS (expect ds), R_ERR.
- ws and rvalid are decoded from registered state and counter only. They never depend on same-cycle inputs.
- R_IDLE:
  - rd=1: addr<=start_addr; rem<=max(burst_len,1); rdata<=mem[start_addr]; beat_cnt<=0; go to R_PH2.
  - ds=1 with rd=0: go to R_ERR.
  - Otherwise stay.
- R_PH2:
  - Outputs: rvalid=1; ws=(rem>1).
  - rd=0: go to R_ERR.
  - rem>1: addr<=addr+1 (wraps mod 2**AW); rem<=rem-1; beat_cnt<=beat_cnt+1; go to R_PH1.
  - Else: beat_cnt<=beat_cnt+1; go to R_WDS.
- R_PH1:
  - rd=1: rdata<=mem[addr]; go to R_PH2.
  - Else: go to R_ERR.
- R_WDS:
  - ds=1 and rd=0: done=1 for one cycle starting the next cycle; go to R_IDLE.
  - Otherwise: go to R_ERR.
- R_ERR:
  - err=1 while in this state; ws=0, rvalid=0.
  - Return to R_IDLE on the first cycle with rd=0 and ds=0.
- Latency:
  - rdata is loaded on the edge that enters R_PH2.
  - It is therefore valid in the same cycle the initiator samples ws.
  - Each beat takes 2 cycles; a full burst takes 2*N+1 cycles including the ds cycle.
- Host writes:
  - Accepted in every state: mem[waddr]<=wdata on the clk edge.
  - If a write and an rdata load hit the same address on the same edge, rdata gets the old value.
- rdata holds its last value outside R_PH2.
- beat_cnt holds after the burst until the next burst start.
- Address wrap: start_addr=2**AW-1 with N>1 continues at address 0.

Test Plan:
- Reset, then preload mem[2..4]=0x11,0x22,0x33. Set start_addr=2, burst_len=3 and drive the initiator sequence: READ, DLY, READ, DLY, READ, DLY, DONE. Required:
  - rdata/rvalid give 0x11, 0x22, 0x33 in the DLY cycles.
  - ws=1,1,0.
  - done pulses once; beat_cnt=3; err=0.
- burst_len=0 with mem[5]=0xA5 and start_addr=5. Required: a single beat, ws=0 in DLY, rdata=0xA5, done pulse, beat_cnt=1.
- Wrap: AW=4, start_addr=15, burst_len=2, mem[15]=0xF0, mem[0]=0x0F. Required: data 0xF0 then 0x0F; ws=1 then 0.
- Protocol violations, each checked separately. Required: err=1 in each case, then recovery to R_IDLE once rd=ds=0, and the next legal burst completes cleanly.
  - rd dropped in the DLY cycle of beat 1.
  - ds missing after the last beat.
  - ds asserted while idle.
- Write collision: host writes 0x77 to mem[2] on the same edge that loads rdata from address 2 (old value 0x11). Required: rdata=0x11 for that beat; the next burst reads 0x77.
- Assert rst_n=0 in the middle of beat 2 of a 4-beat burst. Required: all outputs zero on the next edge, no done pulse, and a new burst afterwards behaves normally.
